// File: rtl/mem_unit.sv
// mem_unit: MAR/MDR bus registers and single-port RAM with a wait-state mfc handshake.
// Define MEM_BOUNDS_EN to add the err pulse for accesses at or beyond DEPTH.
module mem_unit #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_write,
  input  logic              mdr_write,
  input  logic              mdr_read,
  input  logic              mem_en,
  input  logic              mem_rw,
  output logic [DATA_W-1:0] bus_out,
  output logic              mfc
`ifdef MEM_BOUNDS_EN
  ,
  output logic              err
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic              acc_rw;

  logic [DATA_W-1:0] ram [DEPTH];

  logic              in_range;
  logic              done;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_data;

  assign in_range = {1'b0, acc_addr} < DEPTH_L;
  assign done     = (state == BUSY) && (cnt == 4'd0);
  assign idx      = acc_addr[IDX_W-1:0];
  assign rd_data  = in_range ? ram[idx] : '0;
  assign bus_out  = mdr_read ? mdr : '0;

  // RAM is not reset; an access aborted by reset never reaches this write.
  always_ff @(posedge clk) begin
    if (done && !acc_rw && in_range && !reset)
      ram[idx] <= acc_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      mar      <= '0;
      mdr      <= '0;
      mfc      <= 1'b0;
      acc_addr <= '0;
      acc_data <= '0;
      acc_rw   <= 1'b0;
`ifdef MEM_BOUNDS_EN
      err      <= 1'b0;
`endif
    end else begin
`ifdef MEM_BOUNDS_EN
      err <= 1'b0;
`endif
      if (mar_write)
        mar <= bus_in[ADDR_W-1:0];
      if (mdr_write)
        mdr <= bus_in;
      unique case (state)
        IDLE: begin
          if (mem_en) begin
            acc_addr <= mar;
            acc_data <= mdr;
            acc_rw   <= mem_rw;
            cnt      <= CNT_INIT;
            mfc      <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // read result overrides a same-edge mdr_write
            if (acc_rw)
              mdr <= rd_data;
            mfc   <= 1'b0;
            state <= IDLE;
`ifdef MEM_BOUNDS_EN
            err   <= !in_range;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit: randomized transaction-level bench for mem_unit.
// A RAM array model plus MAR/MDR shadows predict every mfc, err and bus_out value.
module tb_mem_unit;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 128;
  localparam int WAIT   = 2;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] bus_in;
  logic              mar_write;
  logic              mdr_write;
  logic              mdr_read;
  logic              mem_en;
  logic              mem_rw;
  logic [DATA_W-1:0] bus_out;
  logic              mfc;
`ifdef MEM_BOUNDS_EN
  logic              err;
`endif

  int checks;
  int failures;

  logic [15:0] model_ram [256];
  logic [7:0]  m_mar;
  logic [15:0] m_mdr;

  mem_unit #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH(DEPTH),
    .WAIT_CYCLES(WAIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus_in(bus_in),
    .mar_write(mar_write),
    .mdr_write(mdr_write),
    .mdr_read(mdr_read),
    .mem_en(mem_en),
    .mem_rw(mem_rw),
    .bus_out(bus_out),
    .mfc(mfc)
`ifdef MEM_BOUNDS_EN
    ,
    .err(err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mar(input logic [7:0] a);
    bus_in    = {8'h00, a};
    mar_write = 1'b1;
    tick();
    mar_write = 1'b0;
    m_mar     = a;
  endtask

  task automatic set_mdr(input logic [15:0] d);
    bus_in    = d;
    mdr_write = 1'b1;
    tick();
    mdr_write = 1'b0;
    m_mdr     = d;
  endtask

  // One access; optional bus traffic during BUSY and MAR update on the request edge.
  task automatic access(input logic rw, input bit noise, input bit mar_same);
    logic [7:0]  a;
    logic [15:0] d;
    logic [7:0]  na;
    logic [15:0] nd;
    bit          mw;
    int          k;
    int          n;
    a      = m_mar;
    d      = m_mdr;
    na     = 8'($urandom);
    mem_en = 1'b1;
    mem_rw = rw;
    if (mar_same) begin
      bus_in    = {8'h00, na};
      mar_write = 1'b1;
    end
    tick();
    mem_en    = 1'b0;
    mar_write = 1'b0;
    if (mar_same)
      m_mar = na;
    check("mfc_rise", {31'd0, mfc}, 32'd1);
    k = noise ? $urandom_range(0, WAIT - 1) : -1;
    n = 0;
    while (mfc === 1'b1 && n < 20) begin
      if (n == k) begin
        nd        = 16'($urandom);
        mw        = 1'($urandom_range(0, 1));
        bus_in    = nd;
        mdr_write = 1'b1;
        mar_write = mw;
        m_mdr     = nd;
        if (mw)
          m_mar = nd[7:0];
      end
      tick();
      mdr_write = 1'b0;
      mar_write = 1'b0;
      n++;
    end
    check("mfc_len", n, WAIT);
    if (!rw) begin
      if (a < DEPTH)
        model_ram[a] = d;
    end else begin
      m_mdr = (a < DEPTH) ? model_ram[a] : 16'h0000;
    end
`ifdef MEM_BOUNDS_EN
    check("err", {31'd0, err}, {31'd0, (a >= DEPTH)});
`endif
    check("mdr", {16'd0, bus_out}, {16'd0, m_mdr});
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    bus_in    = '0;
    mar_write = 1'b0;
    mdr_write = 1'b0;
    mdr_read  = 1'b1;
    mem_en    = 1'b0;
    mem_rw    = 1'b0;
    m_mar     = '0;
    m_mdr     = '0;
    #1;
    check("rst_mfc", {31'd0, mfc}, 32'd0);
    check("rst_bus", {16'd0, bus_out}, 32'd0);
`ifdef MEM_BOUNDS_EN
    check("rst_err", {31'd0, err}, 32'd0);
`endif
    tick();
    tick();
    reset = 1'b0;
    tick();

    // known contents for every implemented word
    for (int i = 0; i < DEPTH; i++) begin
      set_mar(8'(i));
      set_mdr(16'($urandom));
      access(1'b0, 1'b0, 1'b0);
    end

    // write then read back
    set_mar(8'h10);
    set_mdr(16'hBEEF);
    access(1'b0, 1'b0, 1'b0);
    set_mdr(16'h0000);
    access(1'b1, 1'b0, 1'b0);
    check("rd_beef", {16'd0, bus_out}, 32'h0000BEEF);

    // bus traffic while busy must not disturb the in-flight write
    set_mar(8'h20);
    set_mdr(16'h1111);
    access(1'b0, 1'b1, 1'b0);
    set_mar(8'h20);
    access(1'b1, 1'b0, 1'b0);
    check("rd_20", {16'd0, bus_out}, 32'h00001111);
    set_mar(8'h30);
    access(1'b1, 1'b0, 1'b0);

    // back-to-back with mem_en held high
    set_mar(8'h10);
    mem_en = 1'b1;
    mem_rw = 1'b1;
    for (int i = 1; i <= 2 * (WAIT + 1); i++) begin
      tick();
      check("b2b_mfc", {31'd0, mfc}, {31'd0, ((i % (WAIT + 1)) != 0)});
    end
    mem_en = 1'b0;
    m_mdr  = model_ram[8'h10];
    check("b2b_mdr", {16'd0, bus_out}, {16'd0, m_mdr});

    // reset aborts an in-flight write
    set_mar(8'h05);
    set_mdr(16'hAAAA);
    mem_en = 1'b1;
    mem_rw = 1'b0;
    tick();
    mem_en = 1'b0;
    check("abort_mfc1", {31'd0, mfc}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_mfc0", {31'd0, mfc}, 32'd0);
    check("abort_bus", {16'd0, bus_out}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    m_mar = '0;
    m_mdr = '0;
    set_mar(8'h05);
    access(1'b1, 1'b0, 1'b0);

    // out-of-range write and read
    set_mar(8'h80);
    set_mdr(16'h5A5A);
    access(1'b0, 1'b0, 1'b0);
    set_mdr(16'h1234);
    access(1'b1, 1'b0, 1'b0);
    check("oor_rd", {16'd0, bus_out}, 32'd0);
`ifdef MEM_BOUNDS_EN
    tick();
    check("err_one", {31'd0, err}, 32'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: set_mar(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, DEPTH - 1)));
        1: set_mdr(16'($urandom));
        default: access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));
      endcase
    end

    mdr_read = 1'b0;
    #1;
    check("no_read", {16'd0, bus_out}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
